// File: rtl/score_text_gen.sv
// -----------------------------------------------------------------------------
// score_text_gen
//
// Turns a binary game value (score, round, shots) into two ASCII decimal
// digits and hands them to the character RAM as a single load. The tens digit
// is found by subtracting 10 one step per clock, so there is no divider.
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   update     in   1   request a conversion of value (ignored while busy)
//   value      in   8   unsigned value, captured on the edge that accepts update
//   busy       out  1   high from the accepting edge until the load has gone out
//   load_text  out  1   one-cycle strobe; text_in is valid while it is high
//   text_in    out  16  {tens ASCII, ones ASCII}; held between loads
//
// Parameters
//   BLANK_LEADING_ZERO  1: a zero tens digit is sent as a space; 0: as '0'
//   MAX_VALUE           saturation limit, must be <= 99
// -----------------------------------------------------------------------------
module score_text_gen #(
    parameter bit          BLANK_LEADING_ZERO = 1'b1,
    parameter int unsigned MAX_VALUE          = 99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update,
    input  logic [7:0]  value,
    output logic        busy,
    output logic        load_text,
    output logic [15:0] text_in
);

    localparam logic [7:0]  ZERO_TENS_CHAR = BLANK_LEADING_ZERO ? 8'h20 : 8'h30;
    localparam logic [15:0] TEXT_RESET     = {ZERO_TENS_CHAR, 8'h30};
    localparam logic [7:0]  MAX_VALUE_8    = 8'(MAX_VALUE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [6:0]  rem_reg,   rem_next;
    logic [3:0]  tens_reg,  tens_next;
    logic [15:0] text_reg,  text_next;
    logic        load_reg,  load_next;
    logic        busy_reg,  busy_next;

    logic [7:0]  tens_char;
    logic [7:0]  ones_char;

    // Only the leading digit is ever blanked; a lone zero still shows '0'.
    always_comb begin
        tens_char = (tens_reg == 4'd0) ? ZERO_TENS_CHAR : (8'h30 + {4'd0, tens_reg});
        ones_char = 8'h30 + {1'b0, rem_reg};
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        tens_next  = tens_reg;
        text_next  = text_reg;
        load_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (update) begin
                    // Compare at full 8 bits so e.g. 200 saturates instead of wrapping.
                    rem_next   = (value > MAX_VALUE_8) ? MAX_VALUE_8[6:0] : value[6:0];
                    tens_next  = 4'd0;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (rem_reg >= 7'd10) begin
                    rem_next  = rem_reg - 7'd10;
                    tens_next = tens_reg + 4'd1;
                end else begin
                    // text_in only ever moves here, together with the strobe.
                    text_next  = {tens_char, ones_char};
                    load_next  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered copy of (state != IDLE) so busy tracks the state exactly.
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rem_reg   <= 7'd0;
            tens_reg  <= 4'd0;
            text_reg  <= TEXT_RESET;
            load_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            tens_reg  <= tens_next;
            text_reg  <= text_next;
            load_reg  <= load_next;
            busy_reg  <= busy_next;
        end
    end

    assign busy      = busy_reg;
    assign load_text = load_reg;
    assign text_in   = text_reg;

endmodule
